// File: rtl/switch_matrix_cfg_loader_if.sv
// Valid/ready stream of 6-bit routing entries into the switch matrix configuration loader.
interface switch_matrix_cfg_loader_if;
  logic       cfg_valid;
  logic [5:0] cfg_data;
  logic       cfg_last;
  logic       cfg_ready;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/switch_matrix_cfg_loader.sv
// Routing switch matrix configuration loader: receives one entry per pin,
// checks legality and frame length, stages the frame in shadow registers and
// commits it atomically to the active configuration bus.
module switch_matrix_cfg_loader #(
  parameter int unsigned N_TB = 5,
  parameter int unsigned N_LR = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  switch_matrix_cfg_loader_if.slave      cfg_if,
  input  logic                           cfg_clear,
  output logic [6*(2*N_TB+2*N_LR)-1:0]   cfg_out,
  output logic                           cfg_done,
  output logic                           cfg_err,
  output logic [1:0]                     err_code,
  output logic                           busy
);

  localparam int unsigned N_ENT  = 2*N_TB + 2*N_LR;
  localparam int unsigned CFG_W  = 6*N_ENT;
  localparam int unsigned CNT_W  = $clog2(N_ENT + 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    APPLY = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   cfg_out_q, cfg_out_d;
  logic               ill_q, ill_d;
  logic               len_q, len_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;
  logic               ready_c;
  logic               accept_c;

  // Entry k targets a fixed pin; an entry is illegal if its source pin is out
  // of range, its side code is undefined, or it routes the target to itself.
  function automatic logic entry_illegal(input logic [CNT_W-1:0] k, input logic [5:0] e);
    int unsigned ki;
    int unsigned ti;
    int unsigned x;
    logic [2:0]  ts;
    logic        ill;
    ki = 32'(k);
    x  = 32'(e[5:3]);
    if (ki < N_TB) begin
      ts = 3'd1; ti = ki;
    end else if (ki < 2*N_TB) begin
      ts = 3'd3; ti = ki - N_TB;
    end else if (ki < 2*N_TB + N_LR) begin
      ts = 3'd4; ti = ki - 2*N_TB;
    end else begin
      ts = 3'd2; ti = ki - 2*N_TB - N_LR;
    end
    case (e[2:0])
      3'd0:       ill = 1'b0;
      3'd1, 3'd3: ill = (x >= N_TB);
      3'd2, 3'd4: ill = (x >= N_LR);
      default:    ill = 1'b1;
    endcase
    if ((e[2:0] == ts) && (x == ti)) ill = 1'b1;
    return ill;
  endfunction

  assign ready_c          = ((state_q == IDLE) && !cfg_clear) || (state_q == LOAD) || (state_q == DRAIN);
  assign accept_c         = cfg_if.cfg_valid && ready_c;
  assign cfg_if.cfg_ready = ready_c;

  assign cfg_out  = cfg_out_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;

  // Next-state, shadow staging and commit/reject decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    cfg_out_d  = cfg_out_q;
    ill_d      = ill_q;
    len_d      = len_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        if (cfg_clear) begin
          cfg_out_d = '0;
        end else if (accept_c) begin
          shadow_d[5:0] = cfg_if.cfg_data;
          cnt_d         = CNT_W'(1);
          ill_d         = entry_illegal('0, cfg_if.cfg_data);
          if (cfg_if.cfg_last) begin
            len_d   = 1'b1;
            state_d = APPLY;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          shadow_d[32'(cnt_q)*6 +: 6] = cfg_if.cfg_data;
          ill_d = ill_q | entry_illegal(cnt_q, cfg_if.cfg_data);
          cnt_d = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 1 < N_ENT) begin
            if (cfg_if.cfg_last) begin
              len_d   = 1'b1;
              state_d = APPLY;
            end
          end else if (cfg_if.cfg_last) begin
            state_d = APPLY;
          end else begin
            len_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept_c && cfg_if.cfg_last) state_d = APPLY;
      end
      APPLY: begin
        if (len_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_LEN;
        end else if (ill_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_ILL;
        end else begin
          cfg_out_d  = shadow_q;
          done_d     = 1'b1;
          err_code_d = ERR_NONE;
        end
        cnt_d   = '0;
        ill_d   = 1'b0;
        len_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      cfg_out_q  <= '0;
      ill_q      <= 1'b0;
      len_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      cfg_out_q  <= cfg_out_d;
      ill_q      <= ill_d;
      len_q      <= len_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// Directed bench for switch_matrix_cfg_loader.
module tb_switch_matrix_cfg_loader;

  localparam int unsigned N_ENT = 18;
  localparam int unsigned CFG_W = 6*N_ENT;

  logic             clk;
  logic             rst_n;
  logic             cfg_clear;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_done;
  logic             cfg_err;
  logic [1:0]       err_code;
  logic             busy;

  int n_cmp;
  int n_err;

  logic [5:0]       fr [0:31];
  logic [CFG_W-1:0] exp_out;
  logic [CFG_W-1:0] prev_out;

  switch_matrix_cfg_loader_if cfg_if ();

  switch_matrix_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_if    (cfg_if.slave),
    .cfg_clear (cfg_clear),
    .cfg_out   (cfg_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Base frame: every entry sources top pin 1, except top[1] which is tri-stated.
  task automatic base_frame();
    for (int i = 0; i < 32; i++) fr[i] = 6'b001_001;
    fr[1] = 6'b000_000;
  endtask

  function automatic logic [CFG_W-1:0] pack_frame();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_ENT; i++) v[i*6 +: 6] = fr[i];
    return v;
  endfunction

  // Drive beats on the falling edge; every beat must see ready high.
  task automatic send_beats(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = fr[i];
      cfg_if.cfg_last  = (i == n - 1);
      #1;
      chk($sformatf("%s_ready_b%0d", tag, i + 1), CFG_W'(cfg_if.cfg_ready), CFG_W'(1'b1));
      @(posedge clk);
    end
  endtask

  // Full frame followed by the APPLY cycle and the result cycle checks.
  task automatic run_frame(input int n, input string tag, input logic exp_done,
                           input logic [1:0] exp_code, input logic [CFG_W-1:0] exp_cfg);
    prev_out = cfg_out;
    send_beats(n, tag);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    #1;
    chk({tag, "_apply_ready"}, CFG_W'(cfg_if.cfg_ready), CFG_W'(1'b0));
    chk({tag, "_apply_busy"},  CFG_W'(busy), CFG_W'(1'b1));
    chk({tag, "_apply_hold"},  cfg_out, prev_out);
    @(negedge clk);
    chk({tag, "_done"},  CFG_W'(cfg_done), CFG_W'(exp_done));
    chk({tag, "_err"},   CFG_W'(cfg_err),  CFG_W'(!exp_done));
    chk({tag, "_code"},  CFG_W'(err_code), CFG_W'(exp_code));
    chk({tag, "_out"},   cfg_out, exp_cfg);
    chk({tag, "_busy"},  CFG_W'(busy), CFG_W'(1'b0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cfg_clear = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;
    base_frame();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out",   cfg_out, '0);
    chk("rst_done",  CFG_W'(cfg_done), '0);
    chk("rst_err",   CFG_W'(cfg_err), '0);
    chk("rst_code",  CFG_W'(err_code), '0);
    chk("rst_busy",  CFG_W'(busy), '0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", CFG_W'(cfg_if.cfg_ready), CFG_W'(1'b1));

    // Legal frame commits.
    base_frame();
    exp_out = pack_frame();
    run_frame(18, "legal", 1'b1, 2'b00, exp_out);
    chk("legal_top1", CFG_W'(cfg_out[11:6]), '0);
    for (int i = 0; i < 18; i++)
      if (i != 1) chk($sformatf("legal_ent%0d", i), CFG_W'(cfg_out[i*6 +: 6]), CFG_W'(6'h09));
    @(negedge clk);
    chk("done_one_cycle", CFG_W'(cfg_done), '0);

    // Short frame.
    run_frame(17, "short", 1'b0, 2'b01, exp_out);

    // Out-of-range source pin on left[3].
    base_frame();
    fr[13] = 6'b100_010;
    run_frame(18, "range", 1'b0, 2'b10, exp_out);

    // Long frame drains extra beats.
    base_frame();
    run_frame(20, "long", 1'b0, 2'b01, exp_out);

    // Self-loop on bottom[0].
    base_frame();
    fr[5] = 6'b000_011;
    run_frame(18, "selfloop", 1'b0, 2'b10, exp_out);

    // Clear together with a beat in IDLE: clear wins.
    @(negedge clk);
    cfg_clear = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 6'b001_001;
    cfg_if.cfg_last  = 1'b0;
    #1;
    chk("clr_ready", CFG_W'(cfg_if.cfg_ready), '0);
    @(negedge clk);
    cfg_clear = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    #1;
    chk("clr_out",  cfg_out, '0);
    chk("clr_code", CFG_W'(err_code), CFG_W'(2'b10));
    chk("clr_busy", CFG_W'(busy), '0);
    chk("clr_done", CFG_W'(cfg_done), '0);
    chk("clr_err",  CFG_W'(cfg_err), '0);

    // Reset in the middle of a frame.
    base_frame();
    send_beats(9, "mid");
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out",  cfg_out, '0);
    chk("midrst_code", CFG_W'(err_code), '0);
    chk("midrst_busy", CFG_W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    base_frame();
    fr[0]  = 6'b011_011;
    fr[17] = 6'b000_100;
    exp_out = pack_frame();
    run_frame(18, "after_rst", 1'b1, 2'b00, exp_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
